// File: rtl/mem_bus_arbiter.sv
// Three-way arbiter (icache, dcache, retire buffer) for a single tagged memory port.
// Tracks accepted tags so completions are routed back to the requester that issued them.
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int NUM_TAGS     = 16,
  localparam int TAG_W       = $clog2(NUM_TAGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       ic_command,
  input  logic [63:0]      ic_addr,
  input  logic [1:0]       dc_command,
  input  logic [63:0]      dc_addr,
  input  logic [1:0]       rb_command,
  input  logic [63:0]      rb_addr,
  input  logic [63:0]      rb_data,
  input  logic             rb_full,
  output logic [TAG_W-1:0] ic_response,
  output logic [TAG_W-1:0] dc_response,
  output logic [TAG_W-1:0] rb_response,
  output logic [TAG_W-1:0] ic_tag,
  output logic [TAG_W-1:0] dc_tag,
  output logic [TAG_W-1:0] rb_tag,
  output logic [63:0]      ic_data,
  output logic [63:0]      dc_data,
  output logic [1:0]       proc2mem_command,
  output logic [63:0]      proc2mem_addr,
  output logic [63:0]      proc2mem_data,
  input  logic [TAG_W-1:0] mem2proc_response,
  input  logic [TAG_W-1:0] mem2proc_tag,
  input  logic [63:0]      mem2proc_data,
  output logic [1:0]       grant_owner,
  output logic [4:0]       outstanding,
  output logic             tag_err
);
  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IC   = 2'd1;
  localparam logic [1:0] OWN_DC   = 2'd2;
  localparam logic [1:0] OWN_RB   = 2'd3;
  localparam logic [2:0] LIMIT    = 3'(STARVE_LIMIT);

  // Handshake: a requester presents command/addr(/data) and holds them stable
  // while valid (command != BUS_NONE); the transfer completes in the cycle its
  // *_response is nonzero, after which it may drop or present a new request.
  typedef enum logic {LK_IDLE, LK_HELD} lock_state_t;

  lock_state_t      lock_state, lock_next;
  logic [1:0]       lock_owner, lock_owner_next;
  logic [2:0]       ic_starve, dc_starve, rb_starve;
  logic [NUM_TAGS-1:0] valid, valid_next;
  logic [1:0]       owner [NUM_TAGS];
  logic [1:0]       owner_next [NUM_TAGS];
  logic [4:0]       outstanding_next;
  logic             ic_pend, dc_pend, rb_pend, grant_pend, accepted;
  logic [1:0]       grant, comp_owner;
  logic             tag_miss;

  assign ic_pend = (ic_command != BUS_NONE);
  assign dc_pend = (dc_command != BUS_NONE);
  assign rb_pend = (rb_command != BUS_NONE);

  always_comb begin
    grant = OWN_NONE;
    if (lock_state == LK_HELD)               grant = lock_owner;
    else if (dc_pend && dc_starve >= LIMIT)  grant = OWN_DC;
    else if (rb_pend && rb_starve >= LIMIT)  grant = OWN_RB;
    else if (ic_pend && ic_starve >= LIMIT)  grant = OWN_IC;
    else if (rb_pend && rb_full)             grant = OWN_RB;
    else if (dc_pend)                        grant = OWN_DC;
    else if (rb_pend)                        grant = OWN_RB;
    else if (ic_pend)                        grant = OWN_IC;
  end

  always_comb begin
    grant_pend       = 1'b0;
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    case (grant)
      OWN_IC: begin grant_pend = ic_pend; proc2mem_command = ic_command; proc2mem_addr = ic_addr; end
      OWN_DC: begin grant_pend = dc_pend; proc2mem_command = dc_command; proc2mem_addr = dc_addr; end
      OWN_RB: begin
        grant_pend = rb_pend; proc2mem_command = rb_command;
        proc2mem_addr = rb_addr; proc2mem_data = rb_data;
      end
      default: ;
    endcase
  end

  assign accepted    = grant_pend && (mem2proc_response != '0);
  assign grant_owner = grant;
  assign ic_response = (grant == OWN_IC) ? mem2proc_response : '0;
  assign dc_response = (grant == OWN_DC) ? mem2proc_response : '0;
  assign rb_response = (grant == OWN_RB) ? mem2proc_response : '0;

  // Lock holds the port for a grantee the memory has not yet accepted.
  always_comb begin
    lock_next       = lock_state;
    lock_owner_next = lock_owner;
    case (lock_state)
      LK_IDLE: if (grant_pend && mem2proc_response == '0) begin
        lock_next       = LK_HELD;
        lock_owner_next = grant;
      end
      LK_HELD: if (!grant_pend || mem2proc_response != '0) lock_next = LK_IDLE;
      default: lock_next = LK_IDLE;
    endcase
  end

  always_comb begin
    comp_owner = OWN_NONE;
    tag_miss   = 1'b0;
    if (mem2proc_tag != '0) begin
      if (valid[mem2proc_tag]) comp_owner = owner[mem2proc_tag];
      else                     tag_miss   = 1'b1;
    end
  end

  assign ic_tag  = (comp_owner == OWN_IC) ? mem2proc_tag  : '0;
  assign dc_tag  = (comp_owner == OWN_DC) ? mem2proc_tag  : '0;
  assign rb_tag  = (comp_owner == OWN_RB) ? mem2proc_tag  : '0;
  assign ic_data = (comp_owner == OWN_IC) ? mem2proc_data : '0;
  assign dc_data = (comp_owner == OWN_DC) ? mem2proc_data : '0;

  // Clear before set so a same-cycle reissue of a completing tag keeps the entry.
  always_comb begin
    valid_next = valid;
    owner_next = owner;
    if (comp_owner != OWN_NONE) valid_next[mem2proc_tag] = 1'b0;
    if (accepted) begin
      valid_next[mem2proc_response] = 1'b1;
      owner_next[mem2proc_response] = grant;
    end
    outstanding_next = '0;
    for (int i = 0; i < NUM_TAGS; i++) outstanding_next = outstanding_next + 5'(valid_next[i]);
  end

  function automatic logic [2:0] starve_next(input logic pend, input logic granted,
                                             input logic acc, input logic [2:0] cnt);
    if (!pend || (granted && acc)) return 3'd0;
    if (!granted) return (cnt == 3'd7) ? cnt : cnt + 3'd1;
    return cnt;
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lock_state  <= LK_IDLE;
      lock_owner  <= OWN_NONE;
      ic_starve   <= '0;
      dc_starve   <= '0;
      rb_starve   <= '0;
      valid       <= '0;
      for (int i = 0; i < NUM_TAGS; i++) owner[i] <= OWN_NONE;
      outstanding <= '0;
      tag_err     <= 1'b0;
    end else begin
      lock_state  <= lock_next;
      lock_owner  <= lock_owner_next;
      ic_starve   <= starve_next(ic_pend, grant == OWN_IC, accepted, ic_starve);
      dc_starve   <= starve_next(dc_pend, grant == OWN_DC, accepted, dc_starve);
      rb_starve   <= starve_next(rb_pend, grant == OWN_RB, accepted, rb_starve);
      valid       <= valid_next;
      owner       <= owner_next;
      outstanding <= outstanding_next;
      if (tag_miss) tag_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: arbitration, lock, starvation, tag routing, reset.
module tb_mem_bus_arbiter;
  localparam logic [1:0] NONE = 2'd0, LOAD = 2'd1, STORE = 2'd2;

  logic clock, reset;
  logic [1:0] ic_command, dc_command, rb_command, proc2mem_command, grant_owner;
  logic [63:0] ic_addr, dc_addr, rb_addr, rb_data, ic_data, dc_data;
  logic [63:0] proc2mem_addr, proc2mem_data, mem2proc_data;
  logic rb_full, tag_err;
  logic [3:0] ic_response, dc_response, rb_response, ic_tag, dc_tag, rb_tag;
  logic [3:0] mem2proc_response, mem2proc_tag;
  logic [4:0] outstanding;
  int checks = 0, failures = 0;

  mem_bus_arbiter #(.STARVE_LIMIT(4), .NUM_TAGS(16)) dut (
    .clock(clock), .reset(reset),
    .ic_command(ic_command), .ic_addr(ic_addr),
    .dc_command(dc_command), .dc_addr(dc_addr),
    .rb_command(rb_command), .rb_addr(rb_addr), .rb_data(rb_data), .rb_full(rb_full),
    .ic_response(ic_response), .dc_response(dc_response), .rb_response(rb_response),
    .ic_tag(ic_tag), .dc_tag(dc_tag), .rb_tag(rb_tag),
    .ic_data(ic_data), .dc_data(dc_data),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
    .mem2proc_response(mem2proc_response), .mem2proc_tag(mem2proc_tag), .mem2proc_data(mem2proc_data),
    .grant_owner(grant_owner), .outstanding(outstanding), .tag_err(tag_err)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    ic_command = NONE; dc_command = NONE; rb_command = NONE; rb_full = 1'b0;
    ic_addr = '0; dc_addr = '0; rb_addr = '0; rb_data = '0;
    mem2proc_response = '0; mem2proc_tag = '0; mem2proc_data = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    #3;
    checks++; if (proc2mem_command !== NONE) begin failures++; $display("FAIL rst_cmd got=%0d exp=0", proc2mem_command); end
    checks++; if (grant_owner !== 2'd0) begin failures++; $display("FAIL rst_grant got=%0d exp=0", grant_owner); end
    checks++; if (outstanding !== 5'd0) begin failures++; $display("FAIL rst_outstanding got=%0d exp=0", outstanding); end
    checks++; if (tag_err !== 1'b0) begin failures++; $display("FAIL rst_tag_err got=%0d exp=0", tag_err); end
    checks++; if (dc_response !== 4'd0 || dc_tag !== 4'd0) begin failures++; $display("FAIL rst_dc resp=%0d tag=%0d exp=0", dc_response, dc_tag); end
    reset = 1'b1;
    step();
    #1;
    checks++; if (grant_owner !== 2'd0 || proc2mem_command !== NONE) begin failures++; $display("FAIL post_rst grant=%0d cmd=%0d exp=0", grant_owner, proc2mem_command); end
  endtask

  task automatic test_accept();
    step();
    dc_command = LOAD; dc_addr = 64'h1000; ic_command = LOAD; ic_addr = 64'h2000; mem2proc_response = 4'd3;
    #1;
    checks++; if (grant_owner !== 2'd2) begin failures++; $display("FAIL acc_grant got=%0d exp=2", grant_owner); end
    checks++; if (dc_response !== 4'd3) begin failures++; $display("FAIL acc_dc_resp got=%0d exp=3", dc_response); end
    checks++; if (ic_response !== 4'd0) begin failures++; $display("FAIL acc_ic_resp got=%0d exp=0", ic_response); end
    checks++; if (proc2mem_addr !== 64'h1000 || proc2mem_command !== LOAD) begin failures++; $display("FAIL acc_port addr=%h cmd=%0d exp=1000/1", proc2mem_addr, proc2mem_command); end
    checks++; if (proc2mem_data !== 64'h0) begin failures++; $display("FAIL acc_data got=%h exp=0", proc2mem_data); end
    step();
    idle();
    #1;
    checks++; if (outstanding !== 5'd1) begin failures++; $display("FAIL acc_outstanding got=%0d exp=1", outstanding); end
  endtask

  task automatic test_complete();
    mem2proc_tag = 4'd3; mem2proc_data = 64'hDEAD_BEEF_0000_0003;
    #1;
    checks++; if (dc_tag !== 4'd3) begin failures++; $display("FAIL cmp_dc_tag got=%0d exp=3", dc_tag); end
    checks++; if (dc_data !== 64'hDEAD_BEEF_0000_0003) begin failures++; $display("FAIL cmp_dc_data got=%h exp=deadbeef00000003", dc_data); end
    checks++; if (ic_tag !== 4'd0 || ic_data !== 64'h0) begin failures++; $display("FAIL cmp_ic tag=%0d data=%h exp=0", ic_tag, ic_data); end
    step();
    mem2proc_tag = '0;
    #1;
    checks++; if (outstanding !== 5'd0) begin failures++; $display("FAIL cmp_outstanding got=%0d exp=0", outstanding); end
    checks++; if (tag_err !== 1'b0) begin failures++; $display("FAIL cmp_tag_err_early got=%0d exp=0", tag_err); end
    mem2proc_tag = 4'd9;
    #1;
    checks++; if (dc_tag !== 4'd0 || ic_tag !== 4'd0 || rb_tag !== 4'd0) begin failures++; $display("FAIL bad_tag_routed dc=%0d ic=%0d rb=%0d exp=0", dc_tag, ic_tag, rb_tag); end
    step();
    mem2proc_tag = '0;
    #1;
    checks++; if (tag_err !== 1'b1) begin failures++; $display("FAIL bad_tag_err got=%0d exp=1", tag_err); end
  endtask

  task automatic test_rb_priority();
    step();
    dc_command = LOAD; dc_addr = 64'h3000; rb_command = STORE; rb_addr = 64'h4000; rb_data = 64'h5555;
    rb_full = 1'b0; mem2proc_response = 4'd5;
    #1;
    checks++; if (grant_owner !== 2'd2 || dc_response !== 4'd5) begin failures++; $display("FAIL fixed_pri grant=%0d dc_resp=%0d exp=2/5", grant_owner, dc_response); end
    checks++; if (proc2mem_data !== 64'h0 || rb_response !== 4'd0) begin failures++; $display("FAIL fixed_pri_data data=%h rb_resp=%0d exp=0", proc2mem_data, rb_response); end
    step();
    dc_addr = 64'h3100; rb_full = 1'b1; mem2proc_response = 4'd6;
    #1;
    checks++; if (grant_owner !== 2'd3) begin failures++; $display("FAIL rb_full_grant got=%0d exp=3", grant_owner); end
    checks++; if (proc2mem_command !== STORE || proc2mem_addr !== 64'h4000) begin failures++; $display("FAIL rb_port cmd=%0d addr=%h exp=2/4000", proc2mem_command, proc2mem_addr); end
    checks++; if (proc2mem_data !== 64'h5555) begin failures++; $display("FAIL rb_data got=%h exp=5555", proc2mem_data); end
    checks++; if (rb_response !== 4'd6 || dc_response !== 4'd0) begin failures++; $display("FAIL rb_resp rb=%0d dc=%0d exp=6/0", rb_response, dc_response); end
    step();
    rb_command = NONE; rb_full = 1'b0; mem2proc_response = 4'd7;
    #1;
    checks++; if (grant_owner !== 2'd2 || dc_response !== 4'd7) begin failures++; $display("FAIL dc_after_rb grant=%0d resp=%0d exp=2/7", grant_owner, dc_response); end
    step();
    idle();
    mem2proc_tag = 4'd6; mem2proc_data = 64'hAAAA;
    #1;
    checks++; if (rb_tag !== 4'd6) begin failures++; $display("FAIL store_rb_tag got=%0d exp=6", rb_tag); end
    checks++; if (dc_tag !== 4'd0 || dc_data !== 64'h0) begin failures++; $display("FAIL store_dc tag=%0d data=%h exp=0", dc_tag, dc_data); end
    step();
    mem2proc_tag = '0;
    #1;
    checks++; if (outstanding !== 5'd2) begin failures++; $display("FAIL rb_outstanding got=%0d exp=2", outstanding); end
  endtask

  task automatic test_starve();
    logic [1:0] exp_grant;
    step();
    ic_command = LOAD; ic_addr = 64'h6000;
    for (int i = 0; i < 5; i++) begin
      dc_command = LOAD; dc_addr = 64'h7000 + 64'(i); mem2proc_response = 4'(8 + i);
      #1;
      exp_grant = (i == 4) ? 2'd1 : 2'd2;
      checks++; if (grant_owner !== exp_grant) begin failures++; $display("FAIL starve_grant cyc=%0d got=%0d exp=%0d", i, grant_owner, exp_grant); end
      if (i == 4) begin
        checks++; if (ic_response !== 4'd12 || dc_response !== 4'd0) begin failures++; $display("FAIL starve_resp ic=%0d dc=%0d exp=12/0", ic_response, dc_response); end
      end
      step();
    end
    idle();
    #1;
    checks++; if (outstanding !== 5'd7) begin failures++; $display("FAIL starve_outstanding got=%0d exp=7", outstanding); end
  endtask

  task automatic test_lock();
    step();
    dc_command = LOAD; dc_addr = 64'h8000; mem2proc_response = 4'd0;
    #1;
    checks++; if (grant_owner !== 2'd2 || dc_response !== 4'd0) begin failures++; $display("FAIL lock_c0 grant=%0d resp=%0d exp=2/0", grant_owner, dc_response); end
    step();
    ic_command = LOAD; ic_addr = 64'h9000; rb_command = STORE; rb_addr = 64'hA000; rb_data = 64'h77; rb_full = 1'b1;
    #1;
    checks++; if (grant_owner !== 2'd2 || proc2mem_addr !== 64'h8000) begin failures++; $display("FAIL lock_hold grant=%0d addr=%h exp=2/8000", grant_owner, proc2mem_addr); end
    step();
    mem2proc_response = 4'd13;
    #1;
    checks++; if (grant_owner !== 2'd2 || dc_response !== 4'd13 || rb_response !== 4'd0) begin failures++; $display("FAIL lock_accept grant=%0d dc=%0d rb=%0d exp=2/13/0", grant_owner, dc_response, rb_response); end
    step();
    dc_command = NONE; mem2proc_response = 4'd14;
    #1;
    checks++; if (grant_owner !== 2'd3 || rb_response !== 4'd14) begin failures++; $display("FAIL lock_release grant=%0d rb=%0d exp=3/14", grant_owner, rb_response); end
    step();
    rb_command = NONE; rb_full = 1'b0; mem2proc_response = 4'd15;
    #1;
    checks++; if (grant_owner !== 2'd1 || ic_response !== 4'd15) begin failures++; $display("FAIL lock_ic grant=%0d ic=%0d exp=1/15", grant_owner, ic_response); end
    step();
    idle();
    #1;
    checks++; if (outstanding !== 5'd10) begin failures++; $display("FAIL lock_outstanding got=%0d exp=10", outstanding); end
  endtask

  task automatic test_same_tag();
    step();
    ic_command = LOAD; ic_addr = 64'hB000; mem2proc_response = 4'd5; mem2proc_tag = 4'd5; mem2proc_data = 64'h1234;
    #1;
    checks++; if (dc_tag !== 4'd5 || dc_data !== 64'h1234) begin failures++; $display("FAIL same_dc tag=%0d data=%h exp=5/1234", dc_tag, dc_data); end
    checks++; if (ic_response !== 4'd5 || ic_tag !== 4'd0) begin failures++; $display("FAIL same_ic resp=%0d tag=%0d exp=5/0", ic_response, ic_tag); end
    step();
    ic_command = NONE; mem2proc_response = '0; mem2proc_data = 64'h4321;
    #1;
    checks++; if (outstanding !== 5'd10) begin failures++; $display("FAIL same_outstanding got=%0d exp=10", outstanding); end
    checks++; if (ic_tag !== 4'd5 || ic_data !== 64'h4321 || dc_tag !== 4'd0) begin failures++; $display("FAIL same_reown ic_tag=%0d ic_data=%h dc_tag=%0d exp=5/4321/0", ic_tag, ic_data, dc_tag); end
    step();
    idle();
    #1;
    checks++; if (outstanding !== 5'd9) begin failures++; $display("FAIL same_final got=%0d exp=9", outstanding); end
  endtask

  task automatic test_reset_mid();
    step();
    dc_command = LOAD; dc_addr = 64'hC000;
    step();
    #2;
    reset = 1'b0;
    #1;
    checks++; if (outstanding !== 5'd0) begin failures++; $display("FAIL mid_rst_outstanding got=%0d exp=0", outstanding); end
    checks++; if (tag_err !== 1'b0) begin failures++; $display("FAIL mid_rst_tag_err got=%0d exp=0", tag_err); end
    idle();
    reset = 1'b1;
    step();
    mem2proc_tag = 4'd7; mem2proc_data = 64'h9999;
    #1;
    checks++; if (dc_tag !== 4'd0 || dc_data !== 64'h0) begin failures++; $display("FAIL stale_routed tag=%0d data=%h exp=0", dc_tag, dc_data); end
    step();
    mem2proc_tag = '0;
    #1;
    checks++; if (tag_err !== 1'b1) begin failures++; $display("FAIL stale_tag_err got=%0d exp=1", tag_err); end
  endtask

  initial begin
    test_reset();
    test_accept();
    test_complete();
    test_rb_priority();
    test_starve();
    test_lock();
    test_same_tag();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, 4, consecutive denied cycles after which a pending requester is promoted to top priority.
REQ-002 Parameter: NUM_TAGS, 16, size of the tag-owner table; one entry per MEM_TAG_T value, tag 0 never used.
REQ-003 clock  in  1  single system clock; all state updates on posedge.
REQ-004 reset  in  1  asynchronous, active-low; asserting it (0) clears all state immediately, independent of clock.
REQ-005 ic_command  in  BUS_COMMAND; ic_addr  in  64  icache load request.
REQ-006 dc_command  in  BUS_COMMAND; dc_addr  in  64  dcache load request.
REQ-007 rb_command  in  BUS_COMMAND; rb_addr  in  64; rb_data  in  64; rb_full  in  1  retire-buffer store request and its full flag.
REQ-008 ic_response / dc_response / rb_response  out  MEM_TAG_T  per-requester acceptance tag; 0 = not accepted.
REQ-009 ic_tag / dc_tag / rb_tag  out  MEM_TAG_T  per-requester completion tag; ic_data / dc_data  out  64  load return data.
REQ-010 proc2mem_command  out  BUS_COMMAND; proc2mem_addr  out  64; proc2mem_data  out  64  shared memory port.
REQ-011 mem2proc_response  in  MEM_TAG_T; mem2proc_tag  in  MEM_TAG_T; mem2proc_data  in  64  memory replies.
REQ-012 grant_owner  out  2  current owner (0 none, 1 IC, 2 DC, 3 RB); outstanding  out  5  valid table entries; tag_err  out  1  sticky.

Function
REQ-013 A requester is pending when its command != BUS_NONE; it holds command/addr/data stable until its *_response is nonzero.
REQ-014 Grant is combinational each cycle, first match: (a) locked owner; (b) requester with starve count >= STARVE_LIMIT, ties DC>RB>IC; (c) RB if rb_full; (d) fixed DC>RB>IC.
REQ-015 proc2mem_* carry the granted requester's command/addr; proc2mem_data = rb_data for RB grant, else 0; no grant -> BUS_NONE, addr 0, data 0.
REQ-016 Granted requester's *_response = mem2proc_response same cycle; all others' *_response = 0.
REQ-017 Lock: set at edge when grantee is pending and mem2proc_response == 0; cleared at edge on acceptance (response != 0) or grantee dropping its command.
REQ-018 Acceptance: on nonzero mem2proc_response, table[response] <= {valid=1, owner=grantee} at the edge.
REQ-019 Completion: mem2proc_tag != 0 with valid entry -> owner's *_tag = mem2proc_tag, owner's *_data = mem2proc_data (loads) same cycle; others' tag/data 0; entry cleared at edge.
REQ-020 mem2proc_tag != 0 with invalid entry: no tag routed, tag_err set and held until reset.
REQ-021 Same-cycle acceptance and completion on the same tag: completion routed, entry ends valid with new owner (set wins).
REQ-022 Starve counters: per requester, 3-bit saturating at 7; +1 when pending and not granted; cleared when accepted or not pending.
REQ-023 outstanding = count of valid entries, range 0..15; updated same edge as table.
REQ-024 Stores complete via rb_tag exactly like loads; rb has no data return.

Reset
REQ-025 reset = 0: table all invalid, lock clear, starve counters 0, tag_err 0, outstanding 0.
REQ-026 During reset and first cycle after with no requests: proc2mem_command = BUS_NONE, all *_response/*_tag = 0, grant_owner = 0.
REQ-027 Reset mid-transaction drops outstanding tags; subsequent completions for them raise tag_err.

Verification
REQ-028 DC and IC load same cycle, mem2proc_response=3 -> dc_response=3, ic_response=0, table[3]=DC, outstanding=1.
REQ-029 RB store with rb_full=1 vs DC load -> RB granted, proc2mem_command=BUS_STORE, proc2mem_data=rb_data.
REQ-030 IC pending while DC issues back-to-back loads 5 cycles -> IC granted no later than cycle 5 (STARVE_LIMIT=4).
REQ-031 DC granted, mem2proc_response=0 two cycles, then IC arrives -> lock keeps DC granted until accepted.
REQ-032 mem2proc_tag=3 after REQ-028 -> dc_tag=3, dc_data=mem2proc_data, entry cleared, outstanding=0; mem2proc_tag=9 unissued -> tag_err=1.
